// File: rtl/forwarding_hazard_unit_pkg.sv
// forwarding_hazard_unit_pkg: shared types for the forwarding/hazard unit.
// Select codes, FSM states, shadow-stage record and small helpers.
package forwarding_hazard_unit_pkg;

  localparam int ADDR_W = 5;
  localparam int N_REGS = 32;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_WB      = 2'b01;
  localparam logic [1:0] FWD_ALU     = 2'b10;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } fsm_state_t;

  typedef logic [ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rs;
    reg_addr_t rt;
    reg_addr_t rd;
    logic      regwrite;
    logic      memread;
  } stage_t;

  localparam stage_t BUBBLE = '0;

  // r0 is hardwired zero; addresses past the register count never exist.
  function automatic logic live_reg(reg_addr_t r, int nregs);
    return (r != '0) && (int'(r) < nregs);
  endfunction

  function automatic logic drives(stage_t s, int nregs);
    return s.valid & s.regwrite & live_reg(s.rd, nregs);
  endfunction

endpackage

// File: rtl/forwarding_hazard_unit_if.sv
// forwarding_hazard_unit_if: ID-side controls in, EX-side selects out.
// master = pipeline control / ID stage, slave = forwarding_hazard_unit.
interface forwarding_hazard_unit_if
  import forwarding_hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = ADDR_W
);

  logic                      i_enable;
  logic                      i_flush;
  logic                      i_id_valid;
  logic [REG_ADDR_WIDTH-1:0] i_id_rs;
  logic [REG_ADDR_WIDTH-1:0] i_id_rt;
  logic [REG_ADDR_WIDTH-1:0] i_id_rd;
  logic                      i_id_regwrite;
  logic                      i_id_memread;
  logic [1:0]                o_cortocircuitoA;
  logic [1:0]                o_cortocircuitoB;
  logic                      o_stall;
  logic                      o_ex_valid;

  modport master (
    output i_enable,
    output i_flush,
    output i_id_valid,
    output i_id_rs,
    output i_id_rt,
    output i_id_rd,
    output i_id_regwrite,
    output i_id_memread,
    input  o_cortocircuitoA,
    input  o_cortocircuitoB,
    input  o_stall,
    input  o_ex_valid
  );

  modport slave (
    input  i_enable,
    input  i_flush,
    input  i_id_valid,
    input  i_id_rs,
    input  i_id_rt,
    input  i_id_rd,
    input  i_id_regwrite,
    input  i_id_memread,
    output o_cortocircuitoA,
    output o_cortocircuitoB,
    output o_stall,
    output o_ex_valid
  );

endinterface

// File: rtl/forwarding_hazard_unit_fwd_select.sv
// fwd_select: 2-bit operand select from EX/MEM and MEM/WB records.
// Ports: src (EX source reg), exmem, memwb (shadow stages), sel (out).
module fwd_select
  import forwarding_hazard_unit_pkg::*;
#(
  parameter int NUM_REGS = N_REGS
) (
  input  reg_addr_t  src,
  input  stage_t     exmem,
  input  stage_t     memwb,
  output logic [1:0] sel
);

  logic hit_alu;
  logic hit_wb;

  assign hit_alu = drives(exmem, NUM_REGS)
                 & (exmem.rd == src);
  assign hit_wb  = drives(memwb, NUM_REGS)
                 & (memwb.rd == src);

  // The younger producer (EX/MEM) shadows MEM/WB.
  always_comb begin
    sel = FWD_REGFILE;
    unique case (1'b1)
      hit_alu:            sel = FWD_ALU;
      hit_wb & ~hit_alu:  sel = FWD_WB;
      default:            sel = FWD_REGFILE;
    endcase
  end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// forwarding_hazard_unit: shadow ID/EX..MEM/WB tracking, EX forwarding
// selects, load-use stall. Ports: i_clk, i_reset (sync, active-high),
// bus (slave: enable/flush/ID fields in, selects/stall/ex_valid out).
// FWD_HAZARD_STATS_EN adds o_stall_count / o_fwd_count (saturating).
module forwarding_hazard_unit
  import forwarding_hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = ADDR_W,
  parameter int NUM_REGS       = N_REGS
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  forwarding_hazard_unit_if.slave bus
`ifdef FWD_HAZARD_STATS_EN
  ,
  output logic [31:0]            o_stall_count,
  output logic [31:0]            o_fwd_count
`endif
);

  stage_t     idex;
  stage_t     exmem;
  stage_t     memwb;
  stage_t     id_rec;
  fsm_state_t state;
  fsm_state_t state_nx;
  logic       hazard;
  logic       stall;
  logic [1:0] sel_a;
  logic [1:0] sel_b;

  logic [REG_ADDR_WIDTH-1:0] id_rs;
  logic [REG_ADDR_WIDTH-1:0] id_rt;
  logic [REG_ADDR_WIDTH-1:0] id_rd;

  assign id_rs = bus.i_id_rs;
  assign id_rt = bus.i_id_rt;
  assign id_rd = bus.i_id_rd;

  always_comb begin
    id_rec          = BUBBLE;
    id_rec.valid    = 1'b1;
    id_rec.rs       = id_rs;
    id_rec.rt       = id_rt;
    id_rec.rd       = id_rd;
    id_rec.regwrite = bus.i_id_regwrite;
    id_rec.memread  = bus.i_id_memread;
  end

  // Shadow pipeline
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      idex  <= BUBBLE;
      exmem <= BUBBLE;
      memwb <= BUBBLE;
    end else if (bus.i_enable) begin
      memwb <= exmem;
      exmem <= idex;
      if (stall | bus.i_flush | ~bus.i_id_valid)
        idex <= BUBBLE;
      else
        idex <= id_rec;
    end
  end

  assign hazard = bus.i_id_valid
                & idex.valid
                & idex.memread
                & live_reg(idex.rd, NUM_REGS)
                & ((idex.rd == id_rec.rs)
                 | (idex.rd == id_rec.rt));

  // FSM: state register
  always_ff @(posedge i_clk) begin
    if (i_reset)
      state <= ST_RUN;
    else if (bus.i_enable)
      state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_RUN:   if (stall) state_nx = ST_STALL;
      ST_STALL: state_nx = ST_RUN;
      default:  state_nx = ST_RUN;
    endcase
  end

  // FSM: outputs. STALL masks a re-detect of the same load;
  // a flush kills the ID instruction, so there is nothing to hold.
  always_comb begin
    stall = 1'b0;
    unique case (state)
      ST_RUN:   stall = hazard & ~bus.i_flush;
      ST_STALL: stall = 1'b0;
      default:  stall = 1'b0;
    endcase
  end

  fwd_select #(.NUM_REGS(NUM_REGS)) u_sel_a (
    .src   (idex.rs),
    .exmem (exmem),
    .memwb (memwb),
    .sel   (sel_a)
  );

  fwd_select #(.NUM_REGS(NUM_REGS)) u_sel_b (
    .src   (idex.rt),
    .exmem (exmem),
    .memwb (memwb),
    .sel   (sel_b)
  );

  assign bus.o_cortocircuitoA = sel_a;
  assign bus.o_cortocircuitoB = sel_b;
  assign bus.o_stall          = stall;
  assign bus.o_ex_valid       = idex.valid;

`ifdef FWD_HAZARD_STATS_EN
  logic fwd_any;

  assign fwd_any = (sel_a != FWD_REGFILE)
                 | (sel_b != FWD_REGFILE);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_stall_count <= '0;
      o_fwd_count   <= '0;
    end else if (bus.i_enable) begin
      if (stall && (o_stall_count != '1))
        o_stall_count <= o_stall_count + 32'd1;
      if (fwd_any && (o_fwd_count != '1))
        o_fwd_count <= o_fwd_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// tb_forwarding_hazard_unit: directed vector table plus random stimulus
// against an instruction-level pipeline model.
module tb_forwarding_hazard_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  forwarding_hazard_unit_if #(.REG_ADDR_WIDTH(5)) bus ();

`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] fwd_cnt;
`endif

  forwarding_hazard_unit dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
`ifdef FWD_HAZARD_STATS_EN
    ,
    .o_stall_count (stall_cnt),
    .o_fwd_count   (fwd_cnt)
`endif
  );

  typedef struct {
    bit rst, en, fl, v;
    int rs, rt, rd;
    bit rw, mr;
    int a, b;
    bit st, ev;
  } vec_t;

  typedef struct {
    bit v;
    int rs, rt, rd;
    bit rw, mr;
  } ins_t;

  vec_t tbl[$];
  int checks = 0;
  int failures = 0;

  // Model: slot 0 = EX, 1 = MEM, 2 = WB
  ins_t pipe[3];
  bit was_stalled;
  longint n_stall, n_fwd;

  function automatic vec_t mk(bit r, bit e, bit f, bit v,
                              int rs, int rt, int rd,
                              bit rw, bit mr,
                              int a, int b, bit st, bit ev);
    vec_t t;
    t.rst = r; t.en = e; t.fl = f; t.v = v;
    t.rs = rs; t.rt = rt; t.rd = rd;
    t.rw = rw; t.mr = mr;
    t.a = a; t.b = b; t.st = st; t.ev = ev;
    return t;
  endfunction

  function automatic vec_t nop(int a, int b, bit st, bit ev);
    return mk(0, 1, 0, 0, 0, 0, 0, 0, 0, a, b, st, ev);
  endfunction

  // Newest older producer of src wins; MEM -> ALU result, WB -> writeback.
  function automatic int m_sel(int src);
    for (int k = 1; k <= 2; k++)
      if (pipe[k].v && pipe[k].rw && pipe[k].rd != 0
          && pipe[k].rd == src)
        return (k == 1) ? 2 : 1;
    return 0;
  endfunction

  function automatic bit m_stall(vec_t t);
    return !was_stalled && !t.fl && t.v && pipe[0].v && pipe[0].mr
        && pipe[0].rd != 0
        && (pipe[0].rd == t.rs || pipe[0].rd == t.rt);
  endfunction

  task automatic m_clear();
    for (int k = 0; k < 3; k++) pipe[k] = '{default: 0};
    was_stalled = 0;
    n_stall = 0;
    n_fwd = 0;
  endtask

  task automatic m_clock(vec_t t);
    bit s;
    if (t.rst) begin
      m_clear();
    end else if (t.en) begin
      s = m_stall(t);
      if (s) n_stall++;
      if (m_sel(pipe[0].rs) != 0 || m_sel(pipe[0].rt) != 0) n_fwd++;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (s || t.fl || !t.v)
        pipe[0] = '{default: 0};
      else
        pipe[0] = '{1, t.rs, t.rt, t.rd, t.rw, t.mr};
      was_stalled = s;
    end
  endtask

  task automatic drive(vec_t t);
    rst               = t.rst;
    bus.i_enable      = t.en;
    bus.i_flush       = t.fl;
    bus.i_id_valid    = t.v;
    bus.i_id_rs       = 5'(t.rs);
    bus.i_id_rt       = 5'(t.rt);
    bus.i_id_rd       = 5'(t.rd);
    bus.i_id_regwrite = t.rw;
    bus.i_id_memread  = t.mr;
  endtask

  task automatic check(string name, logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {bus.o_cortocircuitoA, bus.o_cortocircuitoB,
            bus.o_stall, bus.o_ex_valid};
  endfunction

  initial begin
    vec_t t;
    vec_t prev;
    logic [5:0] exp;

    // Back-to-back ALU dependency
    tbl.push_back(nop(0, 0, 0, 0));
    tbl.push_back(mk(0,1,0,1, 1,2,3, 1,0, 0,0,0,0));
    tbl.push_back(mk(0,1,0,1, 3,5,4, 1,0, 0,0,0,1));
    tbl.push_back(nop(2, 0, 0, 1));
    tbl.push_back(nop(0, 0, 0, 0));
    // One-apart dependency
    tbl.push_back(mk(0,1,0,1, 1,2,3, 1,0, 0,0,0,0));
    tbl.push_back(nop(0, 0, 0, 1));
    tbl.push_back(mk(0,1,0,1, 5,3,6, 1,0, 0,0,0,0));
    tbl.push_back(nop(0, 1, 0, 1));
    tbl.push_back(nop(0, 0, 0, 0));
    // Double match
    tbl.push_back(mk(0,1,0,1, 1,2,3, 1,0, 0,0,0,0));
    tbl.push_back(mk(0,1,0,1, 1,2,3, 1,0, 0,0,0,1));
    tbl.push_back(mk(0,1,0,1, 3,3,7, 1,0, 0,0,0,1));
    tbl.push_back(nop(2, 2, 0, 1));
    tbl.push_back(nop(0, 0, 0, 0));
    tbl.push_back(nop(0, 0, 0, 0));
    // Load-use
    tbl.push_back(mk(0,1,0,1, 2,0,8, 1,1, 0,0,0,0));
    tbl.push_back(mk(0,1,0,1, 8,1,9, 1,0, 0,0,1,1));
    tbl.push_back(mk(0,1,0,1, 8,1,9, 1,0, 0,0,0,0));
    tbl.push_back(nop(1, 0, 0, 1));
    tbl.push_back(nop(0, 0, 0, 0));
    // Load to r0
    tbl.push_back(mk(0,1,0,1, 2,0,0, 1,1, 0,0,0,0));
    tbl.push_back(mk(0,1,0,1, 0,1,9, 1,0, 0,0,0,1));
    tbl.push_back(nop(0, 0, 0, 1));
    tbl.push_back(nop(0, 0, 0, 0));
    // Flush together with hazard
    tbl.push_back(mk(0,1,0,1, 2,0,8, 1,1, 0,0,0,0));
    tbl.push_back(mk(0,1,1,1, 8,1,9, 1,0, 0,0,0,1));
    tbl.push_back(nop(0, 0, 0, 0));
    tbl.push_back(nop(0, 0, 0, 0));
    // Reset while in STALL
    tbl.push_back(mk(0,1,0,1, 2,0,8, 1,1, 0,0,0,0));
    tbl.push_back(mk(0,1,0,1, 8,1,9, 1,0, 0,0,1,1));
    tbl.push_back(mk(1,1,0,1, 8,1,9, 1,0, 0,0,0,0));
    tbl.push_back(nop(0, 0, 0, 0));
    // Enable low for 3 cycles mid-sequence
    tbl.push_back(mk(0,1,0,1, 1,2,3, 1,0, 0,0,0,0));
    tbl.push_back(mk(0,1,0,1, 3,5,4, 1,0, 0,0,0,1));
    tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0, 2,0,0,1));
    tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0, 2,0,0,1));
    tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0, 2,0,0,1));
    tbl.push_back(nop(2, 0, 0, 1));
    tbl.push_back(nop(0, 0, 0, 0));
    // Enable low while a load-use stall is pending
    tbl.push_back(mk(0,1,0,1, 2,0,8, 1,1, 0,0,0,0));
    tbl.push_back(mk(0,0,0,1, 8,1,9, 1,0, 0,0,1,1));
    tbl.push_back(mk(0,0,0,1, 8,1,9, 1,0, 0,0,1,1));
    tbl.push_back(mk(0,1,0,1, 8,1,9, 1,0, 0,0,1,1));
    tbl.push_back(mk(0,1,0,1, 8,1,9, 1,0, 0,0,0,0));
    tbl.push_back(nop(1, 0, 0, 1));
    tbl.push_back(nop(0, 0, 0, 0));

    // Reset
    t = mk(1,1,0,0, 0,0,0, 0,0, 0,0,0,0);
    drive(t);
    m_clear();
    @(posedge clk); #1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      t = tbl[i];
      drive(t);
      #4;
      check($sformatf("vec%0d", i), 32'(outs()),
            32'({2'(t.a), 2'(t.b), t.st, t.ev}));
      m_clock(t);
      @(posedge clk); #1;
    end

    // Random phase against the model
    prev = nop(0, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      t = mk($urandom_range(0, 59) == 0,
             $urandom_range(0, 4) != 0,
             $urandom_range(0, 9) == 0,
             $urandom_range(0, 4) != 0,
             $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3),
             $urandom_range(0, 1) == 1,
             $urandom_range(0, 2) == 0,
             0, 0, 0, 0);
      // A stalled ID stage usually keeps its instruction
      if (was_stalled && $urandom_range(0, 1) == 1) begin
        t.v = prev.v; t.rs = prev.rs; t.rt = prev.rt;
        t.rd = prev.rd; t.rw = prev.rw; t.mr = prev.mr;
      end
      drive(t);
      #4;
      exp = {2'(m_sel(pipe[0].rs)), 2'(m_sel(pipe[0].rt)),
             m_stall(t), pipe[0].v};
      check($sformatf("rnd%0d", n), 32'(outs()), 32'(exp));
      m_clock(t);
      prev = t;
      @(posedge clk); #1;
    end

`ifdef FWD_HAZARD_STATS_EN
    check("stall_count", stall_cnt, 32'(n_stall));
    check("fwd_count", fwd_cnt, 32'(n_fwd));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
